present80_key_sched: RTL and testbench
======================================

# present80_key_sched

Sequencer for the PRESENT-80 key schedule. Holds the 80-bit key register, applies the per-round update (rotate, S-box, round-counter XOR), and hands the 32 round keys K1..K32 to the cipher datapath over a valid/ready handshake. It sits between key loading and the round-function datapath and replaces ad-hoc key-register multiplexing with a single counted schedule.

## Interface
Parameters:
- NUM_RK, 32, number of round keys emitted per schedule (PRESENT-80: 31 rounds + final whitening)

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  synchronous, active-low; sampled on clk rising edge
- key_in  input  80  user key, sampled on accepted load
- key_load  input  1  start request; accepted only in IDLE
- round_key  output  64  current round key = key register [79:16]
- round_idx  output  5  index of the presented key, 1..NUM_RK, encoded modulo 32 (32 encodes as 0)
- rk_valid  output  1  round_key/round_idx valid
- rk_ready  input  1  datapath consumes the presented key
- busy  output  1  high from load acceptance until done
- done  output  1  one-cycle pulse after the last key is accepted
- decrypt  input  1  present only with PRESENT_KS_DECRYPT_EN; sampled with key_load

## Operation
- States: IDLE, FWD (decrypt only), EMIT, DONE.
- IDLE: busy=0, rk_valid=0. key_load=1 loads key_in into key register, sets rcnt=1 and round_idx=1, and goes to EMIT (or FWD when decrypt=1).
- Forward update, for rcnt i = 1..31: K ← K rotated left 61; K[79:76] ← S(K[79:76]); K[19:15] ← K[19:15] ^ i.
- EMIT: rk_valid=1; round_key and round_idx stay stable until rk_valid and rk_ready are both high. On acceptance:
  - if round_idx < NUM_RK, apply the update, increment round_idx, stay in EMIT;
  - else go to DONE.
- DONE: done=1 for one cycle, rk_valid=0, busy=0 (deasserted on DONE entry), then go to IDLE.
- key_load outside IDLE is ignored, with no effect on the key or counters.
- rk_ready while rk_valid=0 is ignored.
- rcnt is 5 bits and only takes values 1..31. The XOR never uses 0 or 32.
- Reset (reset=0) at any point: state IDLE, key register 0, round_idx 0, rcnt 0, all outputs 0 on the next edge. Any schedule in progress is aborted.

## Timing
- Load accepted at edge t: rk_valid=1 with round_key=key_in[79:16] and round_idx=1 from t+1.
- With rk_ready held high, one key is accepted per cycle, so K1..K32 are accepted at t+1..t+32. done is high during t+33, and IDLE is re-entered at t+34.
- A stalled rk_ready holds all outputs; there is no latency penalty beyond the stall.
- The update is combinational from the key register and registered on the accept edge. round_key is a direct register slice, with no extra output stage.

## Configuration
- PRESENT_KS_DECRYPT_EN defined:
  - The decrypt port exists.
  - Load with decrypt=1 enters FWD. It applies 31 forward updates, one per cycle, with rk_valid=0, then enters EMIT presenting K32.
  - Each accept then applies the inverse update and decrements round_idx, down to K1: K[19:15] ^= (round_idx−1); K[79:76] ← S⁻¹(K[79:76]); K rotated left 19.
  - First rk_valid occurs at t+32.
- PRESENT_KS_DECRYPT_EN undefined:
  - There is no decrypt port, no FWD state and no inverse S-box logic.
  - Every schedule is forward only.

## Structure
- Shared package present80_pkg:
  - S-box and inverse S-box functions;
  - KEY_W=80, RK_W=64, NUM_ROUNDS=31 constants;
  - the state enum.
- Sub-module present80_key_update: combinational single-step update with a direction input. The inverse path is compiled under PRESENT_KS_DECRYPT_EN.

## Test plan
- key_in=0, load, rk_ready=1 -> K1=0000000000000000, K2=C000000000000000, K3=5000180000000001, K32=6DAB31744F41D700. done is high exactly at t+33.
- Random rk_ready stalls on key 0xFFFF…FF -> round_key and round_idx stay stable while stalled, the accepted sequence equals the unstalled run, and there are exactly 32 accepts.
- key_load pulsed during EMIT at round_idx=10 -> ignored, and the sequence continues unchanged.
- reset=0 at round_idx=17 -> next edge gives all outputs 0 and IDLE; a new load restarts from K1.
- (DECRYPT_EN) key_in=0, decrypt=1 -> rk_valid first at t+32 with 6DAB31744F41D700 and round_idx=0 (encodes 32); the last key is K1=0000000000000000.
- Back-to-back loads: load in the IDLE cycle right after done -> a new schedule starts with no lost cycle, and the old key does not leak.

Source files
------------

// File: rtl/present80_pkg.sv
// Shared PRESENT-80 key-schedule definitions: widths, S-box tables and sequencer states.
// PRESENT_KS_DECRYPT_EN adds the FWD state used by the reverse-order schedule.
package present80_pkg;

  localparam int KEY_W      = 80;
  localparam int RK_W       = 64;
  localparam int NUM_ROUNDS = 31;

`ifdef PRESENT_KS_DECRYPT_EN
  typedef enum logic [1:0] {
    KS_IDLE = 2'd0,
    KS_FWD  = 2'd1,
    KS_EMIT = 2'd2,
    KS_DONE = 2'd3
  } ks_state_e;
`else
  typedef enum logic [1:0] {
    KS_IDLE = 2'd0,
    KS_EMIT = 2'd2,
    KS_DONE = 2'd3
  } ks_state_e;
`endif

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h5;
      4'h1: y = 4'hE;
      4'h2: y = 4'hF;
      4'h3: y = 4'h8;
      4'h4: y = 4'hC;
      4'h5: y = 4'h1;
      4'h6: y = 4'h2;
      4'h7: y = 4'hD;
      4'h8: y = 4'hB;
      4'h9: y = 4'h4;
      4'hA: y = 4'h6;
      4'hB: y = 4'h3;
      4'hC: y = 4'h0;
      4'hD: y = 4'h7;
      4'hE: y = 4'h9;
      default: y = 4'hA;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/present80_key_sched_if.sv
// Key-load / round-key bus between the key sequencer (master) and its users (slave).
// PRESENT_KS_DECRYPT_EN adds the decrypt request line.
interface present80_key_sched_if;
  import present80_pkg::*;

  // round_key/round_idx are held while rk_valid && !rk_ready; a key is
  // consumed on the rising edge where rk_valid && rk_ready are both high.
  logic [KEY_W-1:0] key_in;
  logic             key_load;
  logic [RK_W-1:0]  round_key;
  logic [4:0]       round_idx;
  logic             rk_valid;
  logic             rk_ready;
  logic             busy;
  logic             done;
  ks_state_e        dbg_state;
`ifdef PRESENT_KS_DECRYPT_EN
  logic             decrypt;

  modport master (
    input  key_in, key_load, rk_ready, decrypt,
    output round_key, round_idx, rk_valid, busy, done, dbg_state
  );

  modport slave (
    output key_in, key_load, rk_ready, decrypt,
    input  round_key, round_idx, rk_valid, busy, done, dbg_state
  );
`else
  modport master (
    input  key_in, key_load, rk_ready,
    output round_key, round_idx, rk_valid, busy, done, dbg_state
  );

  modport slave (
    output key_in, key_load, rk_ready,
    input  round_key, round_idx, rk_valid, busy, done, dbg_state
  );
`endif

endinterface

// File: rtl/present80_key_update.sv
// One combinational step of the PRESENT-80 key schedule, forward or (with
// PRESENT_KS_DECRYPT_EN) inverse, selected by inv_i.
module present80_key_update
  import present80_pkg::*;
(
  input  logic [KEY_W-1:0] key_i,
  input  logic [4:0]       cnt_i,
  input  logic             inv_i,
  output logic [KEY_W-1:0] key_o
);

  logic [KEY_W-1:0] fwd_rot;
  logic [KEY_W-1:0] fwd_key;

  // Rotate left by 61 is the same as rotate right by 19.
  always_comb begin
    fwd_rot          = {key_i[18:0], key_i[79:19]};
    fwd_key          = fwd_rot;
    fwd_key[79:76]   = sbox(fwd_rot[79:76]);
    fwd_key[19:15]   = fwd_rot[19:15] ^ cnt_i;
  end

`ifdef PRESENT_KS_DECRYPT_EN
  logic [KEY_W-1:0] inv_mix;
  logic [KEY_W-1:0] inv_key;

  // Undo the forward steps in reverse order: counter XOR, S-box, then rotation.
  always_comb begin
    inv_mix        = key_i;
    inv_mix[19:15] = key_i[19:15] ^ cnt_i;
    inv_mix[79:76] = sbox_inv(key_i[79:76]);
    inv_key        = {inv_mix[60:0], inv_mix[79:61]};
  end

  assign key_o = inv_i ? inv_key : fwd_key;
`else
  logic unused_inv;
  assign unused_inv = inv_i;
  assign key_o      = fwd_key;
`endif

endmodule

// File: rtl/present80_key_sched.sv
// PRESENT-80 key-schedule sequencer: loads an 80-bit key and streams K1..K32 over
// a valid/ready bus. PRESENT_KS_DECRYPT_EN enables reverse-order (K32..K1) schedules.
module present80_key_sched
  import present80_pkg::*;
#(
  parameter int NUM_RK = 32
) (
  input logic                 clk,
  input logic                 reset,
  present80_key_sched_if.master bus
);

  localparam logic [4:0] LAST_IDX  = 5'(NUM_RK);
  localparam logic [4:0] LAST_RCNT = 5'(NUM_RK - 1);
  localparam logic [4:0] MAX_RCNT  = 5'd31;

  ks_state_e        state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [4:0]       rcnt_q, rcnt_d;
  logic [4:0]       idx_q, idx_d;

  logic             upd_inv;
  logic [4:0]       upd_cnt;
  logic [KEY_W-1:0] upd_key;
  logic             accept;

`ifdef PRESENT_KS_DECRYPT_EN
  logic dir_q, dir_d;
`endif

  present80_key_update u_update (
    .key_i (key_q),
    .cnt_i (upd_cnt),
    .inv_i (upd_inv),
    .key_o (upd_key)
  );

  assign accept = (state_q == KS_EMIT) && bus.rk_ready;

  // Step control depends only on registered state, keeping the update path loop-free.
  always_comb begin
    upd_inv = 1'b0;
    upd_cnt = rcnt_q;
`ifdef PRESENT_KS_DECRYPT_EN
    if ((state_q == KS_EMIT) && dir_q) begin
      upd_inv = 1'b1;
      upd_cnt = idx_q - 5'd1;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    rcnt_d  = rcnt_q;
    idx_d   = idx_q;
`ifdef PRESENT_KS_DECRYPT_EN
    dir_d   = dir_q;
`endif
    case (state_q)
      KS_IDLE: begin
        if (bus.key_load) begin
          key_d   = bus.key_in;
          rcnt_d  = 5'd1;
          idx_d   = 5'd1;
          state_d = KS_EMIT;
`ifdef PRESENT_KS_DECRYPT_EN
          dir_d   = bus.decrypt;
          if (bus.decrypt) begin
            state_d = KS_FWD;
          end
`endif
        end
      end
`ifdef PRESENT_KS_DECRYPT_EN
      // Walk forward to the last round key before presenting anything.
      KS_FWD: begin
        key_d = upd_key;
        if (rcnt_q == LAST_RCNT) begin
          idx_d   = LAST_IDX;
          state_d = KS_EMIT;
        end else begin
          rcnt_d = rcnt_q + 5'd1;
        end
      end
`endif
      KS_EMIT: begin
        if (accept) begin
`ifdef PRESENT_KS_DECRYPT_EN
          if (dir_q) begin
            if (idx_q == 5'd1) begin
              state_d = KS_DONE;
            end else begin
              key_d = upd_key;
              idx_d = idx_q - 5'd1;
            end
          end else
`endif
          begin
            if (idx_q == LAST_IDX) begin
              state_d = KS_DONE;
            end else begin
              key_d = upd_key;
              idx_d = idx_q + 5'd1;
              // rcnt saturates at 31 so the counter XOR never sees 0 or 32.
              if (rcnt_q != MAX_RCNT) begin
                rcnt_d = rcnt_q + 5'd1;
              end
            end
          end
        end
      end
      KS_DONE: begin
        state_d = KS_IDLE;
      end
      default: begin
        state_d = KS_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= KS_IDLE;
      key_q   <= '0;
      rcnt_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      rcnt_q  <= rcnt_d;
      idx_q   <= idx_d;
    end
  end

`ifdef PRESENT_KS_DECRYPT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      dir_q <= 1'b0;
    end else begin
      dir_q <= dir_d;
    end
  end

  assign bus.busy = (state_q == KS_EMIT) || (state_q == KS_FWD);
`else
  assign bus.busy = (state_q == KS_EMIT);
`endif

  assign bus.round_key = key_q[79:16];
  assign bus.round_idx = idx_q;
  assign bus.rk_valid  = (state_q == KS_EMIT);
  assign bus.done      = (state_q == KS_DONE);
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_present80_key_sched.sv
// Directed bench for present80_key_sched: fixed key-0 vectors, a reference
// schedule model, stalls, ignored loads, mid-run reset and back-to-back loads.
module tb_present80_key_sched;
  import present80_pkg::*;

  typedef struct {
    int          pos;
    logic [4:0]  idx;
    logic [63:0] rk;
  } vec_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  logic [68:0] exp_q[$];
  logic [68:0] got_q[$];
  logic [68:0] ref_q[$];
  logic [3:0]  sbox_t[16];
  vec_t        vecs[4];

  present80_key_sched_if bus();

  present80_key_sched #(.NUM_RK(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [79:0] m_fwd(input logic [79:0] k, input logic [4:0] c);
    logic [79:0] r;
    for (int j = 0; j < 80; j++) r[j] = k[(j + 19) % 80];
    r[79:76] = sbox_t[r[79:76]];
    r[19:15] = r[19:15] ^ c;
    return r;
  endfunction

  // Expected stream of {idx, round_key}; decrypt is the forward list reversed.
  function automatic void build_exp(input logic [79:0] key, input logic dec);
    logic [79:0] k;
    logic [68:0] fwd[$];
    k = key;
    for (int i = 1; i <= 32; i++) begin
      fwd.push_back({5'(i), k[79:16]});
      if (i < 32) k = m_fwd(k, 5'(i));
    end
    exp_q.delete();
    if (dec) begin
      for (int i = 31; i >= 0; i--) exp_q.push_back(fwd[i]);
    end else begin
      exp_q = fwd;
    end
  endfunction

  task automatic compare_q(input string name, input logic [68:0] want_q[$]);
    logic [68:0] g;
    check({name, "_count"}, 80'(got_q.size()), 80'(want_q.size()));
    for (int i = 0; i < want_q.size() && i < got_q.size(); i++) begin
      g = got_q[i];
      check($sformatf("%s_k%0d", name, i), 80'(g), 80'(want_q[i]));
    end
  endtask

  task automatic run_sched(input logic [79:0] key, input logic dec, input int stall_pct,
                           input logic poke, output int first_cyc, output int done_cyc);
    int          cyc;
    logic        prev_stall;
    logic        poked;
    logic [63:0] prev_rk;
    logic [4:0]  prev_idx;
    got_q.delete();
    bus.key_in   = key;
    bus.key_load = 1'b1;
    bus.rk_ready = 1'b0;
`ifdef PRESENT_KS_DECRYPT_EN
    bus.decrypt  = dec;
`else
    if (dec) $display("note: decrypt request ignored in forward-only build");
`endif
    @(posedge clk);
    #1;
    bus.key_load = 1'b0;
    bus.key_in   = ~key;
    cyc        = 1;
    first_cyc  = -1;
    done_cyc   = -1;
    prev_stall = 1'b0;
    prev_rk    = '0;
    prev_idx   = '0;
    poked      = 1'b0;
    while (cyc < 200 && done_cyc < 0) begin
      bus.rk_ready = ($urandom_range(99) >= stall_pct);
      bus.key_load = poke && bus.rk_valid && (bus.round_idx == 5'd10);
      if (bus.key_load) poked = 1'b1;
      @(negedge clk);
      if (bus.rk_valid && first_cyc < 0) first_cyc = cyc;
      if (prev_stall) begin
        check("stall_hold_rk", 80'(bus.round_key), 80'(prev_rk));
        check("stall_hold_idx", 80'(bus.round_idx), 80'(prev_idx));
      end
      if (bus.done) done_cyc = cyc;
      if (bus.rk_valid && bus.rk_ready) got_q.push_back({bus.round_idx, bus.round_key});
      prev_stall = bus.rk_valid && !bus.rk_ready;
      prev_rk    = bus.round_key;
      prev_idx   = bus.round_idx;
      @(posedge clk);
      #1;
      bus.key_load = 1'b0;
      cyc++;
    end
    bus.rk_ready = 1'b0;
    if (done_cyc < 0) check("sched_timeout", 80'(cyc), 80'(0));
    if (poke) check("load_poke_applied", 80'(poked), 80'(1));
  endtask

  initial begin
    int          first_cyc;
    int          done_cyc;
    int          n;
    logic [68:0] g;
    logic [79:0] key_a;
    logic [79:0] key_b;
    logic [79:0] key_f;

    total  = 0;
    bad    = 0;
    key_a  = 80'h0123456789ABCDEF0123;
    key_b  = 80'h8BADF00DCAFEBABE1357;
    key_f  = {80{1'b1}};
    sbox_t = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
               4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
    vecs[0] = '{1,  5'd1, 64'h0000000000000000};
    vecs[1] = '{2,  5'd2, 64'hC000000000000000};
    vecs[2] = '{3,  5'd3, 64'h5000180000000001};
    vecs[3] = '{32, 5'd0, 64'h6DAB31744F41D700};

    reset        = 1'b0;
    bus.key_in   = '0;
    bus.key_load = 1'b0;
    bus.rk_ready = 1'b0;
`ifdef PRESENT_KS_DECRYPT_EN
    bus.decrypt  = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 80'(bus.rk_valid), 80'(0));
    check("rst_busy", 80'(bus.busy), 80'(0));
    check("rst_done", 80'(bus.done), 80'(0));
    check("rst_rk", 80'(bus.round_key), 80'(0));
    check("rst_idx", 80'(bus.round_idx), 80'(0));
    check("rst_state", 80'(bus.dbg_state), 80'(KS_IDLE));
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Key 0, ready held high: table of known round keys plus full model stream.
    run_sched(80'h0, 1'b0, 0, 1'b0, first_cyc, done_cyc);
    check("zero_first_valid", 80'(first_cyc), 80'(1));
    check("zero_done_cycle", 80'(done_cyc), 80'(33));
    for (int v = 0; v < 4; v++) begin
      g = got_q[vecs[v].pos - 1];
      check($sformatf("vec_rk_k%0d", vecs[v].pos), 80'(g[63:0]), 80'(vecs[v].rk));
      check($sformatf("vec_idx_k%0d", vecs[v].pos), 80'(g[68:64]), 80'(vecs[v].idx));
    end
    build_exp(80'h0, 1'b0);
    compare_q("fwd_zero", exp_q);

    // Load in the IDLE cycle right after done: no lost cycle, no old key.
    run_sched(key_f, 1'b0, 0, 1'b0, first_cyc, done_cyc);
    check("b2b_first_valid", 80'(first_cyc), 80'(1));
    check("b2b_done_cycle", 80'(done_cyc), 80'(33));
    g = got_q[0];
    check("ones_k1", 80'(g[63:0]), 80'(64'hFFFFFFFFFFFFFFFF));
    build_exp(key_f, 1'b0);
    compare_q("fwd_ones", exp_q);
    ref_q = got_q;

    @(negedge clk);
    check("idle_after_done", 80'(bus.dbg_state), 80'(KS_IDLE));
    check("idle_busy", 80'(bus.busy), 80'(0));
    @(posedge clk);
    #1;

    // Random stalls must yield the same accepted sequence.
    run_sched(key_f, 1'b0, 40, 1'b0, first_cyc, done_cyc);
    compare_q("stall_ones", ref_q);

    // key_load while emitting round 10 is ignored.
    run_sched(key_a, 1'b0, 0, 1'b1, first_cyc, done_cyc);
    build_exp(key_a, 1'b0);
    compare_q("poke", exp_q);

    // Reset mid-schedule at round_idx 17, then a fresh schedule from K1.
    bus.key_in   = key_a;
    bus.key_load = 1'b1;
    bus.rk_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.key_load = 1'b0;
    n = 0;
    while (!(bus.rk_valid && bus.round_idx == 5'd17) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("reach_idx17", 80'(bus.round_idx), 80'(17));
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_valid", 80'(bus.rk_valid), 80'(0));
    check("mid_rst_busy", 80'(bus.busy), 80'(0));
    check("mid_rst_done", 80'(bus.done), 80'(0));
    check("mid_rst_rk", 80'(bus.round_key), 80'(0));
    check("mid_rst_idx", 80'(bus.round_idx), 80'(0));
    check("mid_rst_state", 80'(bus.dbg_state), 80'(KS_IDLE));
    @(posedge clk);
    #1;
    reset        = 1'b1;
    bus.rk_ready = 1'b0;
    run_sched(key_b, 1'b0, 20, 1'b0, first_cyc, done_cyc);
    check("restart_first_valid", 80'(first_cyc), 80'(1));
    build_exp(key_b, 1'b0);
    compare_q("restart", exp_q);

`ifdef PRESENT_KS_DECRYPT_EN
    run_sched(80'h0, 1'b1, 0, 1'b0, first_cyc, done_cyc);
    check("dec_first_valid", 80'(first_cyc), 80'(32));
    check("dec_done_cycle", 80'(done_cyc), 80'(64));
    g = got_q[0];
    check("dec_first_rk", 80'(g[63:0]), 80'(64'h6DAB31744F41D700));
    check("dec_first_idx", 80'(g[68:64]), 80'(0));
    g = got_q[31];
    check("dec_last_rk", 80'(g[63:0]), 80'(0));
    check("dec_last_idx", 80'(g[68:64]), 80'(1));
    build_exp(80'h0, 1'b1);
    compare_q("dec_zero", exp_q);
    run_sched(key_a, 1'b1, 30, 1'b0, first_cyc, done_cyc);
    build_exp(key_a, 1'b1);
    compare_q("dec_stall", exp_q);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
